my_mod_ramp_gen_v1: RTL and testbench
=====================================

Name: my_mod_ramp_gen_v1

Overview:
- Generates the square-wave bias modulation and the digital phase ramp that drive the modulator DAC.
- Produces the o_status level and o_trig edge pulse consumed by the error-signal generator.
- Consumes that block's step value, step sync and ramp sync pulses, and folds the closed-loop step into a wrapping ramp accumulator.
- Sits between the error/loop-filter path and the DAC interface.

Parameters:
DAC_BIT, 16, width of DAC code output
ACC_W, 32, ramp accumulator width (2π = 2^ACC_W full scale)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  run enable; low forces IDLE
i_half_cnt  in  32  modulation half-period in clocks (effective minimum 2)
i_mod_amp_h  in  32 signed  modulation offset added during high half
i_mod_amp_l  in  32 signed  modulation offset added during low half
i_step  in  32 signed  loop step value
i_step_sync  in  1  pulse: latch i_step into step register
i_ramp_sync  in  1  pulse: add step register to ramp accumulator
o_status  out  1  modulation level (1 = high half)
o_trig  out  1  one-cycle pulse on first clock of each half
o_dac  out  DAC_BIT signed  DAC code
o_ramp  out  ACC_W  ramp accumulator value
o_cstate  out  2  current state (debug)

Behaviour:
- Reset values: o_status=0, o_trig=0, o_dac=0, o_ramp=0; step register=0; half counter=0; state IDLE.
- States and transitions:
  - IDLE -> MOD_H when i_en=1.
  - MOD_H -> MOD_L when counter==1.
  - MOD_L -> MOD_H when counter==1.
  - Any state -> IDLE on the cycle after i_en=0.
- Half-period counter:
  - Loaded on entry to each half with max(i_half_cnt, 2); i_half_cnt is sampled only at that load.
  - Decrements each cycle while in the half.
  - Each half therefore lasts exactly the loaded value in clocks.
- Edge outputs:
  - o_status and o_trig update on the same clock edge as the state change.
  - o_status=1 throughout MOD_H and 0 in MOD_L and IDLE.
  - o_trig=1 only on the first cycle of each half, including the first MOD_H after IDLE.
- DAC code:
  - Registered only on half entry: o_dac <= top DAC_BIT bits of (ramp_acc + amp), with amp = i_mod_amp_h entering MOD_H and i_mod_amp_l entering MOD_L.
  - The add is modulo 2^ACC_W, so it wraps naturally (2π reset); no saturation.
  - o_dac is held constant within a half.
- Ramp and step:
  - i_step_sync: step_reg <= i_step on the next edge.
  - i_ramp_sync: ramp_acc <= ramp_acc + step_reg, modulo 2^ACC_W.
  - If i_step_sync and i_ramp_sync arrive in the same cycle, the ramp uses the old step_reg.
  - A ramp update in the same cycle as a half entry is not reflected in o_dac until the next half entry.
- Disable (i_en low): next cycle state=IDLE, o_status=0, o_trig=0, o_dac=0, ramp_acc=0; step_reg retained.
- Reset mid-operation: all registers return to reset values immediately (asynchronous).
- Sync pulses in IDLE: still update step_reg and ramp_acc, but ramp_acc is cleared every IDLE cycle while i_en=0.

Optional Feature:
- Macro: MOD_RAMP_EN.
- Defined: ramp_acc participates in o_dac as described.
- Undefined:
  - ramp_acc is tied to 0 and o_ramp=0.
  - i_ramp_sync and i_step_sync are ignored.
  - o_dac = top DAC_BIT bits of the selected modulation offset only (open-loop modulation).

Decomposition:
- Package my_mod_pkg:
  - state enum mod_state_t {IDLE=0, MOD_H=1, MOD_L=2}.
  - Constant MIN_HALF_CNT=2.
- One natural sub-module: my_half_timer (load/decrement/terminal-count counter with min-clamp).
- The FSM, DAC register and ramp logic stay in the top module.

Test Plan:
1. Free-run: i_half_cnt=5, amps 0, i_en=1 -> o_trig pulse every 5 clocks; o_status toggles every 5 clocks; first pulse with o_status=1.
2. Min clamp: i_half_cnt=0, then 1 -> each half lasts 2 clocks; o_trig pulses every 2 clocks.
3. Modulation amplitude: amp_h=0x4000_0000, amp_l=0xC000_0000, ramp 0, DAC_BIT=16 -> o_dac alternates 0x4000 / 0xC000 at half entries only.
4. Ramp wrap: step=0x6000_0000, three ramp_sync pulses -> o_ramp=0x6000_0000, 0xC000_0000, 0x2000_0000; o_dac reflects each value at the following half entry.
5. Simultaneous sync: step_reg=10, then i_step=20 with step_sync and ramp_sync together -> ramp += 10; the next ramp_sync adds 20.
6. Disable and reset mid-half: drop i_en mid MOD_H -> next cycle IDLE, all outputs 0. Assert i_rst_n low mid MOD_L -> outputs 0 immediately. With MOD_RAMP_EN undefined, ramp_sync has no effect and o_ramp stays 0.

Source files
------------

// File: rtl/my_mod_ramp_gen_v1_pkg.sv
// Shared types and constants for the modulation/ramp generator.
package my_mod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOD_H = 2'd1,
    MOD_L = 2'd2
  } mod_state_t;

  localparam logic [31:0] MIN_HALF_CNT = 32'd2;

  function automatic logic [31:0] clamp_half(input logic [31:0] v);
    return (v < MIN_HALF_CNT) ? MIN_HALF_CNT : v;
  endfunction

endpackage

// File: rtl/my_mod_ramp_gen_v1_if.sv
// Control/loop inputs and DAC/status outputs of the ramp generator.
interface my_mod_ramp_gen_v1_if #(
  parameter int DAC_BIT = 16,
  parameter int ACC_W   = 32
);
  logic                      i_en;
  logic [31:0]               i_half_cnt;
  logic signed [31:0]        i_mod_amp_h;
  logic signed [31:0]        i_mod_amp_l;
  logic signed [31:0]        i_step;
  logic                      i_step_sync;
  logic                      i_ramp_sync;
  logic                      o_status;
  logic                      o_trig;
  logic signed [DAC_BIT-1:0] o_dac;
  logic [ACC_W-1:0]          o_ramp;
  logic [1:0]                o_cstate;

  modport master (
    output i_en, i_half_cnt, i_mod_amp_h, i_mod_amp_l, i_step, i_step_sync, i_ramp_sync,
    input  o_status, o_trig, o_dac, o_ramp, o_cstate
  );

  modport slave (
    input  i_en, i_half_cnt, i_mod_amp_h, i_mod_amp_l, i_step, i_step_sync, i_ramp_sync,
    output o_status, o_trig, o_dac, o_ramp, o_cstate
  );
endinterface

// File: rtl/my_mod_ramp_gen_v1_half_timer.sv
// Half-period down-counter: load with clamped length, terminal count at 1.
module my_half_timer
  import my_mod_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [31:0] i_half_cnt,
  output logic        o_tc
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = clamp_half(i_half_cnt);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == 32'd1);

endmodule

// File: rtl/my_mod_ramp_gen_v1.sv
// Square-wave bias modulation plus wrapping phase ramp feeding the DAC.
// Closed-loop ramp is enabled by defining MOD_RAMP_EN; otherwise open-loop modulation only.
module my_mod_ramp_gen_v1
  import my_mod_pkg::*;
#(
  parameter int DAC_BIT = 16,
  parameter int ACC_W   = 32
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  my_mod_ramp_gen_v1_if.slave  bus
);

  mod_state_t         state_q, state_d;
  logic               status_q, status_d;
  logic               trig_q, trig_d;
  logic [DAC_BIT-1:0] dac_q, dac_d;
  logic [ACC_W-1:0]   ramp_q;
  logic [ACC_W-1:0]   amp_sel;
  logic [ACC_W-1:0]   dac_sum;
  logic               load;
  logic               tc;

  my_half_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (!bus.i_en),
    .i_load     (load),
    .i_half_cnt (bus.i_half_cnt),
    .o_tc       (tc)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    trig_d   = 1'b0;
    dac_d    = dac_q;
    load     = 1'b0;
    amp_sel  = ACC_W'(bus.i_mod_amp_h);
    if (!bus.i_en) begin
      state_d  = IDLE;
      status_d = 1'b0;
      dac_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = MOD_H;
          load    = 1'b1;
        end
        MOD_H: if (tc) begin
          state_d = MOD_L;
          load    = 1'b1;
          amp_sel = ACC_W'(bus.i_mod_amp_l);
        end
        MOD_L: if (tc) begin
          state_d = MOD_H;
          load    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    // DAC samples the pre-update ramp, so a same-cycle ramp_sync shows up one half later.
    dac_sum = ramp_q + amp_sel;
    if (load) begin
      status_d = (state_d == MOD_H);
      trig_d   = 1'b1;
      dac_d    = dac_sum[ACC_W-1 -: DAC_BIT];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      status_q <= 1'b0;
      trig_q   <= 1'b0;
      dac_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      trig_q   <= trig_d;
      dac_q    <= dac_d;
    end
  end

`ifdef MOD_RAMP_EN
  logic [ACC_W-1:0] step_q, step_d;
  logic [ACC_W-1:0] ramp_d;

  always_comb begin
    step_d = bus.i_step_sync ? ACC_W'(bus.i_step) : step_q;
    ramp_d = ramp_q;
    if (bus.i_ramp_sync) begin
      ramp_d = ramp_q + step_q;
    end
    if (!bus.i_en) begin
      ramp_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_q <= '0;
      ramp_q <= '0;
    end else begin
      step_q <= step_d;
      ramp_q <= ramp_d;
    end
  end
`else
  logic unused_sync;
  assign unused_sync = ^{bus.i_step, bus.i_step_sync, bus.i_ramp_sync};
  assign ramp_q      = '0;
`endif

  assign bus.o_status = status_q;
  assign bus.o_trig   = trig_q;
  assign bus.o_dac    = dac_q;
  assign bus.o_ramp   = ramp_q;
  assign bus.o_cstate = state_q;

endmodule

// File: tb/tb_my_mod_ramp_gen_v1.sv
// Directed self-checking bench for my_mod_ramp_gen_v1 (default and MOD_RAMP_EN builds).
module tb_my_mod_ramp_gen_v1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  my_mod_ramp_gen_v1_if #(.DAC_BIT(16), .ACC_W(32)) bus();

  my_mod_ramp_gen_v1 #(.DAC_BIT(16), .ACC_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_en = 1'b1; bus.i_half_cnt = 32'd5;
    bus.i_mod_amp_h = 32'sh4000_0000; bus.i_mod_amp_l = 32'sh2000_0000;
    bus.i_step = 32'sd7; bus.i_step_sync = 1'b1; bus.i_ramp_sync = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    bus.i_step_sync = 1'b0; bus.i_ramp_sync = 1'b0;
    n_tests++; if (bus.o_status !== 1'b0) begin n_fail++; $display("FAIL reset_status got %0b want 0", bus.o_status); end
    n_tests++; if (bus.o_trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig got %0b want 0", bus.o_trig); end
    n_tests++; if (bus.o_dac !== 16'h0000) begin n_fail++; $display("FAIL reset_dac got %h want 0000", bus.o_dac); end
    n_tests++; if (bus.o_ramp !== 32'h0) begin n_fail++; $display("FAIL reset_ramp got %h want 0", bus.o_ramp); end
    n_tests++; if (bus.o_cstate !== 2'd0) begin n_fail++; $display("FAIL reset_cstate got %0d want 0", bus.o_cstate); end
    bus.i_en = 1'b0;
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus.o_cstate !== 2'd0) begin n_fail++; $display("FAIL reset_idle got %0d want 0", bus.o_cstate); end
  endtask

  task automatic test_free_run();
    logic       exp_trig, exp_st;
    logic [1:0] exp_cs;
    bus.i_half_cnt = 32'd5; bus.i_mod_amp_h = 32'sd0; bus.i_mod_amp_l = 32'sd0;
    bus.i_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_trig = ((k % 5) == 0);
      exp_st   = (((k / 5) % 2) == 0);
      exp_cs   = exp_st ? 2'd1 : 2'd2;
      n_tests++;
      if (bus.o_trig !== exp_trig || bus.o_status !== exp_st || bus.o_cstate !== exp_cs) begin
        n_fail++;
        $display("FAIL free_run k=%0d got trig=%0b st=%0b cs=%0d want trig=%0b st=%0b cs=%0d",
                 k, bus.o_trig, bus.o_status, bus.o_cstate, exp_trig, exp_st, exp_cs);
      end
    end
    bus.i_en = 1'b0;
    tick();
  endtask

  task automatic test_min_clamp();
    logic exp_trig, exp_st;
    for (int h = 0; h < 2; h++) begin
      bus.i_half_cnt = 32'(h);
      bus.i_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        exp_trig = ((k % 2) == 0);
        exp_st   = (((k / 2) % 2) == 0);
        n_tests++;
        if (bus.o_trig !== exp_trig || bus.o_status !== exp_st) begin
          n_fail++;
          $display("FAIL min_clamp half=%0d k=%0d got trig=%0b st=%0b want trig=%0b st=%0b",
                   h, k, bus.o_trig, bus.o_status, exp_trig, exp_st);
        end
      end
      bus.i_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_mod_amp();
    logic [15:0] exp_dac;
    bus.i_half_cnt = 32'd3;
    bus.i_mod_amp_h = 32'sh4000_0000; bus.i_mod_amp_l = 32'shC000_0000;
    n_tests++; if (bus.o_dac !== 16'h0000) begin n_fail++; $display("FAIL amp_idle_dac got %h want 0000", bus.o_dac); end
    bus.i_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      case (k / 3)
        0:       exp_dac = 16'h4000;
        1:       exp_dac = 16'hC000;
        2:       exp_dac = 16'h1234;
        default: exp_dac = 16'hC000;
      endcase
      n_tests++;
      if (bus.o_dac !== exp_dac) begin
        n_fail++; $display("FAIL mod_amp k=%0d got %h want %h", k, bus.o_dac, exp_dac);
      end
      if (k == 1) bus.i_mod_amp_h = 32'sh1234_0000;
    end
    bus.i_en = 1'b0;
    tick();
  endtask

`ifdef MOD_RAMP_EN
  task automatic test_ramp_wrap();
    logic [31:0] exp_ramp;
    logic [15:0] exp_dac;
    bus.i_step = 32'sh6000_0000; bus.i_step_sync = 1'b1;
    tick();
    bus.i_step_sync = 1'b0;
    bus.i_half_cnt = 32'd4; bus.i_mod_amp_h = 32'sd0; bus.i_mod_amp_l = 32'sd0;
    bus.i_en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      exp_ramp = (k >= 8) ? 32'h2000_0000 : (k >= 5) ? 32'hC000_0000 : (k >= 1) ? 32'h6000_0000 : 32'h0;
      exp_dac  = (k >= 12) ? 16'h2000 : (k >= 8) ? 16'hC000 : (k >= 4) ? 16'h6000 : 16'h0000;
      n_tests++;
      if (bus.o_ramp !== exp_ramp || bus.o_dac !== exp_dac) begin
        n_fail++;
        $display("FAIL ramp_wrap k=%0d got ramp=%h dac=%h want ramp=%h dac=%h",
                 k, bus.o_ramp, bus.o_dac, exp_ramp, exp_dac);
      end
      bus.i_ramp_sync = (k == 0 || k == 4 || k == 7);
    end
    bus.i_ramp_sync = 1'b0;
    bus.i_en = 1'b0;
    tick();
  endtask

  task automatic test_sim_sync();
    bus.i_step = 32'sd10; bus.i_step_sync = 1'b1;
    tick();
    bus.i_step_sync = 1'b0;
    bus.i_en = 1'b1;
    tick();
    bus.i_step = 32'sd20; bus.i_step_sync = 1'b1; bus.i_ramp_sync = 1'b1;
    tick();
    bus.i_step_sync = 1'b0; bus.i_ramp_sync = 1'b0;
    n_tests++; if (bus.o_ramp !== 32'd10) begin n_fail++; $display("FAIL sim_sync_old_step got %0d want 10", bus.o_ramp); end
    bus.i_ramp_sync = 1'b1;
    tick();
    bus.i_ramp_sync = 1'b0;
    n_tests++; if (bus.o_ramp !== 32'd30) begin n_fail++; $display("FAIL sim_sync_new_step got %0d want 30", bus.o_ramp); end
    bus.i_en = 1'b0;
    tick();
    n_tests++; if (bus.o_ramp !== 32'd0) begin n_fail++; $display("FAIL disable_ramp_clear got %0d want 0", bus.o_ramp); end
    bus.i_en = 1'b1; bus.i_ramp_sync = 1'b1;
    tick();
    bus.i_ramp_sync = 1'b0;
    n_tests++; if (bus.o_ramp !== 32'd20) begin n_fail++; $display("FAIL step_retained got %0d want 20", bus.o_ramp); end
    bus.i_en = 1'b0;
    tick();
  endtask
`else
  task automatic test_open_loop();
    logic [15:0] exp_dac;
    bus.i_half_cnt = 32'd4; bus.i_mod_amp_h = 32'sh4000_0000; bus.i_mod_amp_l = 32'sd0;
    bus.i_step = 32'sh1000_0000; bus.i_step_sync = 1'b1;
    bus.i_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      bus.i_step_sync = 1'b0;
      bus.i_ramp_sync = (k < 7);
      exp_dac = (((k / 4) % 2) == 0) ? 16'h4000 : 16'h0000;
      n_tests++;
      if (bus.o_ramp !== 32'h0 || bus.o_dac !== exp_dac) begin
        n_fail++;
        $display("FAIL open_loop k=%0d got ramp=%h dac=%h want ramp=0 dac=%h", k, bus.o_ramp, bus.o_dac, exp_dac);
      end
    end
    bus.i_ramp_sync = 1'b0;
    bus.i_en = 1'b0;
    tick();
  endtask
`endif

  task automatic test_disable_reset();
    bus.i_half_cnt = 32'd6; bus.i_mod_amp_h = 32'sh4000_0000; bus.i_mod_amp_l = 32'sh2000_0000;
    bus.i_en = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (bus.o_status !== 1'b1) begin n_fail++; $display("FAIL dis_pre_status got %0b want 1", bus.o_status); end
    bus.i_en = 1'b0;
    tick();
    n_tests++;
    if (bus.o_cstate !== 2'd0 || bus.o_status !== 1'b0 || bus.o_trig !== 1'b0 || bus.o_dac !== 16'h0 || bus.o_ramp !== 32'h0) begin
      n_fail++;
      $display("FAIL disable got cs=%0d st=%0b trig=%0b dac=%h ramp=%h want all 0",
               bus.o_cstate, bus.o_status, bus.o_trig, bus.o_dac, bus.o_ramp);
    end
    bus.i_en = 1'b1;
    tick();
    n_tests++;
    if (bus.o_trig !== 1'b1 || bus.o_status !== 1'b1 || bus.o_cstate !== 2'd1 || bus.o_dac !== 16'h4000) begin
      n_fail++;
      $display("FAIL reenable got trig=%0b st=%0b cs=%0d dac=%h want 1 1 1 4000",
               bus.o_trig, bus.o_status, bus.o_cstate, bus.o_dac);
    end
    for (int k = 0; k < 7; k++) tick();
    n_tests++;
    if (bus.o_status !== 1'b0 || bus.o_cstate !== 2'd2 || bus.o_dac !== 16'h2000) begin
      n_fail++;
      $display("FAIL mid_low got st=%0b cs=%0d dac=%h want 0 2 2000", bus.o_status, bus.o_cstate, bus.o_dac);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.o_cstate !== 2'd0 || bus.o_status !== 1'b0 || bus.o_trig !== 1'b0 || bus.o_dac !== 16'h0 || bus.o_ramp !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset got cs=%0d st=%0b trig=%0b dac=%h ramp=%h want all 0",
               bus.o_cstate, bus.o_status, bus.o_trig, bus.o_dac, bus.o_ramp);
    end
    tick();
    bus.i_en = 1'b0;
    rst_n = 1'b1;
    tick();
`ifdef MOD_RAMP_EN
    bus.i_en = 1'b1; bus.i_ramp_sync = 1'b1;
    tick();
    bus.i_ramp_sync = 1'b0;
    n_tests++; if (bus.o_ramp !== 32'h0) begin n_fail++; $display("FAIL reset_step_cleared got %h want 0", bus.o_ramp); end
    bus.i_en = 1'b0;
    tick();
`endif
  endtask

  initial begin
    bus.i_en = 1'b0; bus.i_half_cnt = '0; bus.i_mod_amp_h = '0; bus.i_mod_amp_l = '0;
    bus.i_step = '0; bus.i_step_sync = 1'b0; bus.i_ramp_sync = 1'b0;
    test_reset();
    test_free_run();
    test_min_clamp();
    test_mod_amp();
`ifdef MOD_RAMP_EN
    test_ramp_wrap();
    test_sim_sync();
`else
    test_open_loop();
`endif
    test_disable_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "timeout");
  end

endmodule
